rob_controller: RTL and testbench

- Owns reorder-buffer bookkeeping: head/tail pointers, occupancy count, full/empty, and a per-entry done bit.
- Sits between the dispatcher (allocation), the commit stage (CDB completions) and the retire stage (in-order release).
- Also handles squash recovery on branch mispredict.
- Tags are 1-based (1..ROB_SIZE); tag 0 means "no tag" everywhere.

---
 rtl/rob_controller_pkg.sv | 14 +
 rtl/rob_in_flight.sv | 29 ++
 rtl/rob_controller.sv | 135 +++++++++++++
 tb/tb_rob_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rob_controller_pkg.sv
// Shared constants, tag type and controller state encoding for the ROB controller.
package rob_controller_pkg;

    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned TAG_W    = 5;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rob_ctrl_state_e;

endpackage

// File: rtl/rob_in_flight.sv
// Combinational test: is a 1-based tag currently between head and tail-1 (with wrap)?
module rob_in_flight #(
    parameter int unsigned ROB_SIZE = rob_controller_pkg::ROB_SIZE,
    parameter int unsigned TAG_W    = rob_controller_pkg::TAG_W
) (
    input  logic [TAG_W-1:0] i_head,
    input  logic [TAG_W-1:0] i_tail,
    input  logic [TAG_W-1:0] i_count,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_in_flight
);

    localparam logic [TAG_W-1:0] LP_SIZE = TAG_W'(ROB_SIZE);

    // head==tail is ambiguous (empty or full), so count settles those two cases first
    always_comb begin
        o_in_flight = 1'b0;
        if (i_tag == '0 || i_tag > LP_SIZE || i_count == '0) begin
            o_in_flight = 1'b0;
        end else if (i_count == LP_SIZE) begin
            o_in_flight = 1'b1;
        end else if (i_head < i_tail) begin
            o_in_flight = (i_tag >= i_head) && (i_tag < i_tail);
        end else begin
            o_in_flight = (i_tag >= i_head) || (i_tag < i_tail);
        end
    end

endmodule

// File: rtl/rob_controller.sv
// Reorder-buffer bookkeeping: pointers, occupancy, done bits and one-cycle squash recovery.
module rob_controller #(
    parameter int unsigned ROB_SIZE = rob_controller_pkg::ROB_SIZE,
    parameter int unsigned TAG_W    = rob_controller_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [TAG_W-1:0] cdb2_tag,
    output logic             retire_valid,
    output logic [TAG_W-1:0] retire_tag,
    input  logic             retire_ack,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    output logic             rob_full,
    output logic             rob_empty,
    output logic [TAG_W-1:0] rob_count,
    output logic             recovering
);

    import rob_controller_pkg::*;

    localparam logic [TAG_W-1:0] LP_SIZE = TAG_W'(ROB_SIZE);
    localparam logic [TAG_W-1:0] LP_ONE  = TAG_W'(1);

    rob_ctrl_state_e     r_state, w_state_n;
    logic [TAG_W-1:0]    r_head, r_tail, r_count;
    logic [TAG_W-1:0]    w_head_n, w_tail_n, w_count_n, w_flush_dist;
    logic [ROB_SIZE-1:0] r_done, w_done_n;
    logic                r_full, r_empty;
    logic                w_cdb1_in, w_cdb2_in, w_flush_in;
    logic                w_grant, w_retire, w_flush_ok, w_head_done;

    function automatic logic [TAG_W-1:0] f_next(input logic [TAG_W-1:0] p);
        return (p == LP_SIZE) ? LP_ONE : p + LP_ONE;
    endfunction

    // Age of a tag relative to head; modular TAG_W arithmetic is exact since the result < ROB_SIZE
    function automatic logic [TAG_W-1:0] f_dist(input logic [TAG_W-1:0] from_p,
                                                 input logic [TAG_W-1:0] to_p);
        return (to_p >= from_p) ? (to_p - from_p) : (to_p + LP_SIZE - from_p);
    endfunction

    rob_in_flight #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_if_cdb1 (
        .i_head(r_head), .i_tail(r_tail), .i_count(r_count), .i_tag(cdb1_tag), .o_in_flight(w_cdb1_in)
    );
    rob_in_flight #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_if_cdb2 (
        .i_head(r_head), .i_tail(r_tail), .i_count(r_count), .i_tag(cdb2_tag), .o_in_flight(w_cdb2_in)
    );
    rob_in_flight #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_if_flush (
        .i_head(r_head), .i_tail(r_tail), .i_count(r_count), .i_tag(flush_tag), .o_in_flight(w_flush_in)
    );

    // Select the done bit of the head entry
    always_comb begin
        w_head_done = 1'b0;
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if (r_head == TAG_W'(i + 1)) w_head_done = r_done[i];
        end
    end

    // Reset gates the grant so a request during reset is never acknowledged
    assign w_grant      = reset & alloc_req & ~r_full & (r_state == RUN) & ~flush;
    assign retire_valid = ~r_empty & w_head_done;
    assign w_retire     = retire_valid & retire_ack;
    assign w_flush_ok   = flush & w_flush_in;
    assign w_flush_dist = f_dist(r_head, flush_tag);

    assign alloc_gnt  = w_grant;
    assign alloc_tag  = r_tail;
    assign retire_tag = r_head;
    assign rob_full   = r_full;
    assign rob_empty  = r_empty;
    assign rob_count  = r_count;
    assign recovering = (r_state == RECOVER);

    // Next pointers, count, done bits and FSM state; squash clearing runs last so it drops same-cycle completions
    always_comb begin
        w_head_n  = r_head;
        w_tail_n  = r_tail;
        w_count_n = r_count;
        w_done_n  = r_done;
        w_state_n = RUN;
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if ((w_cdb1_in && cdb1_tag == TAG_W'(i + 1)) || (w_cdb2_in && cdb2_tag == TAG_W'(i + 1)))
                w_done_n[i] = 1'b1;
            if (w_grant && r_tail == TAG_W'(i + 1))
                w_done_n[i] = 1'b0;
            if (w_retire && r_head == TAG_W'(i + 1))
                w_done_n[i] = 1'b0;
            if (w_flush_ok && f_dist(r_head, TAG_W'(i + 1)) > w_flush_dist)
                w_done_n[i] = 1'b0;
        end
        if (w_retire) w_head_n = f_next(r_head);
        if (w_flush_ok) begin
            w_tail_n  = f_next(flush_tag);
            w_count_n = w_flush_dist + LP_ONE - TAG_W'(w_retire);
            w_state_n = RECOVER;
        end else begin
            if (w_grant) w_tail_n = f_next(r_tail);
            w_count_n = r_count + TAG_W'(w_grant) - TAG_W'(w_retire);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= RUN;
        else        r_state <= w_state_n;
    end

    // Pointer, occupancy and done-bit registers; full/empty track the new count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= LP_ONE;
            r_tail  <= LP_ONE;
            r_count <= '0;
            r_done  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_head  <= w_head_n;
            r_tail  <= w_tail_n;
            r_count <= w_count_n;
            r_done  <= w_done_n;
            r_full  <= (w_count_n == LP_SIZE);
            r_empty <= (w_count_n == '0);
        end
    end

    a_flush_in_flight: assert property (@(posedge clk) disable iff (!reset) flush |-> w_flush_in);

endmodule

// File: tb/tb_rob_controller.sv
// Directed vector bench for rob_controller with a 4-entry ROB.
module tb_rob_controller;

    import rob_controller_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     alloc_req, alloc_gnt, retire_valid, retire_ack, flush;
    logic     rob_full, rob_empty, recovering;
    rob_tag_t alloc_tag, cdb1_tag, cdb2_tag, retire_tag, flush_tag, rob_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob_controller #(.ROB_SIZE(4), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .cdb1_tag(cdb1_tag), .cdb2_tag(cdb2_tag),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_ack(retire_ack),
        .flush(flush), .flush_tag(flush_tag),
        .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
        .recovering(recovering)
    );

    typedef struct {
        logic     alloc;
        rob_tag_t cdb1, cdb2;
        logic     ack, fl;
        rob_tag_t ftag;
        logic     gnt;
        rob_tag_t atag;
        logic     rv;
        rob_tag_t rtag;
        logic     full, empty;
        rob_tag_t cnt;
        logic     rec;
    } vec_t;

    function automatic vec_t mkv(input int alloc, input int cdb1, input int cdb2, input int ack,
                                 input int fl, input int ftag, input int gnt, input int atag,
                                 input int rv, input int rtag, input int full, input int empty,
                                 input int cnt, input int rec);
        vec_t v;
        v.alloc = 1'(alloc); v.cdb1 = 5'(cdb1); v.cdb2 = 5'(cdb2); v.ack = 1'(ack);
        v.fl = 1'(fl); v.ftag = 5'(ftag); v.gnt = 1'(gnt); v.atag = 5'(atag);
        v.rv = 1'(rv); v.rtag = 5'(rtag); v.full = 1'(full); v.empty = 1'(empty);
        v.cnt = 5'(cnt); v.rec = 1'(rec);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input string field, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] %s: got %0d expected %0d", name, idx, field, got, exp);
        end
    endtask

    task automatic check_outs(input vec_t v, input string name, input int idx);
        chk(name, idx, "alloc_gnt",    int'(alloc_gnt),    int'(v.gnt));
        chk(name, idx, "alloc_tag",    int'(alloc_tag),    int'(v.atag));
        chk(name, idx, "retire_valid", int'(retire_valid), int'(v.rv));
        chk(name, idx, "retire_tag",   int'(retire_tag),   int'(v.rtag));
        chk(name, idx, "rob_full",     int'(rob_full),     int'(v.full));
        chk(name, idx, "rob_empty",    int'(rob_empty),    int'(v.empty));
        chk(name, idx, "rob_count",    int'(rob_count),    int'(v.cnt));
        chk(name, idx, "recovering",   int'(recovering),   int'(v.rec));
    endtask

    task automatic drive(input vec_t v);
        alloc_req  = v.alloc;
        cdb1_tag   = v.cdb1;
        cdb2_tag   = v.cdb2;
        retire_ack = v.ack;
        flush      = v.fl;
        flush_tag  = v.ftag;
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle
    task automatic step(input vec_t v, input string name, input int idx);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        check_outs(v, name, idx);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(mkv(0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs(mkv(0,0,0,0,0,0, 0,1,0,1,0,1,0,0), "reset", 0);
        reset = 1'b1;
    endtask

    vec_t tbl[26];

    initial begin
        //            alloc cdb1 cdb2 ack fl ftag | gnt atag rv rtag full empty cnt rec
        tbl[0]  = mkv(1,0,0,0,0,0, 1,1,0,1,0,1,0,0);
        tbl[1]  = mkv(1,0,0,0,0,0, 1,2,0,1,0,0,1,0);
        tbl[2]  = mkv(1,0,0,0,0,0, 1,3,0,1,0,0,2,0);
        tbl[3]  = mkv(1,0,0,0,0,0, 1,4,0,1,0,0,3,0);
        tbl[4]  = mkv(1,0,0,0,0,0, 0,1,0,1,1,0,4,0);   // full: no grant
        tbl[5]  = mkv(0,2,0,0,0,0, 0,1,0,1,1,0,4,0);   // tag 2 done out of order
        tbl[6]  = mkv(0,0,1,0,0,0, 0,1,0,1,1,0,4,0);   // tag 1 done via cdb2
        tbl[7]  = mkv(1,0,0,1,0,0, 0,1,1,1,1,0,4,0);   // full + retire: still no grant
        tbl[8]  = mkv(0,0,0,1,0,0, 0,1,1,2,0,0,3,0);
        tbl[9]  = mkv(0,3,4,0,0,0, 0,1,0,3,0,0,2,0);   // both cdbs at once
        tbl[10] = mkv(1,0,0,1,0,0, 1,1,1,3,0,0,2,0);   // alloc+retire, count held
        tbl[11] = mkv(1,0,0,1,0,0, 1,2,1,4,0,0,2,0);   // head wraps 4->1
        tbl[12] = mkv(0,1,0,0,0,0, 0,3,0,1,0,0,2,0);
        tbl[13] = mkv(1,0,0,1,0,0, 1,3,1,1,0,0,2,0);
        tbl[14] = mkv(1,2,0,0,0,0, 1,4,0,2,0,0,2,0);   // tail wraps 4->1
        tbl[15] = mkv(1,0,0,1,0,0, 1,1,1,2,0,0,3,0);
        tbl[16] = mkv(0,3,3,0,0,0, 0,2,0,3,0,0,3,0);   // same tag on both cdbs
        tbl[17] = mkv(0,0,0,1,0,0, 0,2,1,3,0,0,3,0);
        tbl[18] = mkv(0,2,0,0,0,0, 0,2,0,4,0,0,2,0);   // tag 2 not in flight
        tbl[19] = mkv(0,0,0,1,0,0, 0,2,0,4,0,0,2,0);   // ack without valid
        tbl[20] = mkv(0,4,0,0,0,0, 0,2,0,4,0,0,2,0);
        tbl[21] = mkv(0,0,0,1,0,0, 0,2,1,4,0,0,2,0);
        tbl[22] = mkv(0,0,0,0,0,0, 0,2,0,1,0,0,1,0);
        tbl[23] = mkv(0,1,0,1,0,0, 0,2,0,1,0,0,1,0);   // completion and ack same cycle
        tbl[24] = mkv(0,0,0,1,0,0, 0,2,1,1,0,0,1,0);
        tbl[25] = mkv(0,0,0,0,0,0, 0,2,0,2,0,1,0,0);

        do_reset();
        for (int i = 0; i < 26; i++) step(tbl[i], "tbl", i);

        // Squash younger than tag 2 from a full ROB; completion to squashed tag 3 dropped
        do_reset();
        for (int i = 0; i < 4; i++) step(tbl[i], "sqA", i);
        step(mkv(1,3,2,0,1,2, 0,1,0,1,1,0,4,0), "sqA", 4);
        step(mkv(1,0,0,0,0,0, 0,3,0,1,0,0,2,1), "sqA", 5);
        step(mkv(1,0,0,0,0,0, 1,3,0,1,0,0,2,0), "sqA", 6);
        step(mkv(0,1,0,0,0,0, 0,4,0,1,0,0,3,0), "sqA", 7);
        step(mkv(0,0,0,1,0,0, 0,4,1,1,0,0,3,0), "sqA", 8);
        step(mkv(0,0,0,1,0,0, 0,4,1,2,0,0,2,0), "sqA", 9);
        step(mkv(0,0,0,0,0,0, 0,4,0,3,0,0,1,0), "sqA", 10);

        // Flush at head with same-cycle retire of head: squash to empty
        do_reset();
        step(mkv(1,0,0,0,0,0, 1,1,0,1,0,1,0,0), "sqB", 0);
        step(mkv(1,0,0,0,0,0, 1,2,0,1,0,0,1,0), "sqB", 1);
        step(mkv(1,1,0,0,0,0, 1,3,0,1,0,0,2,0), "sqB", 2);
        step(mkv(0,3,0,1,1,1, 0,4,1,1,0,0,3,0), "sqB", 3);
        step(mkv(1,0,0,0,0,0, 0,2,0,2,0,1,0,1), "sqB", 4);
        step(mkv(1,0,0,0,0,0, 1,2,0,2,0,1,0,0), "sqB", 5);
        step(mkv(0,0,0,0,0,0, 0,3,0,2,0,0,1,0), "sqB", 6);

        // Asynchronous reset between edges during an allocation burst
        do_reset();
        step(mkv(1,0,0,0,0,0, 1,1,0,1,0,1,0,0), "arst", 0);
        step(mkv(1,0,0,0,0,0, 1,2,0,1,0,0,1,0), "arst", 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_outs(mkv(1,0,0,0,0,0, 0,1,0,1,0,1,0,0), "arst", 2);
        @(negedge clk);
        drive(mkv(0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        reset = 1'b1;
        step(mkv(1,0,0,0,0,0, 1,1,0,1,0,1,0,0), "arst", 3);
        step(mkv(0,0,0,0,0,0, 0,2,0,1,0,0,1,0), "arst", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
